// File: rtl/sprite_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_cmd_scheduler
//
// Buffers 32-bit sprite commands written by the Avalon-MM host and replays
// them to the sprite display stages as one-cycle pulses on cmd_out.
// Normal commands (info=1) are issued as soon as they reach the FIFO head.
// Buffer-swap commands (info=F) are held until vertical blanking, and only
// one swap is issued per frame. Commands are always issued in order, so a
// held swap also holds every command queued behind it.
//
// Command word layout on avs_writedata / cmd_out:
//   [31:26] sub_comp  [25:21] child  [20:17] info  [16:14] type
//   [13]    pp_selc   [12:0]  msg
//
// Optional build macro:
//   SCHED_HSYNC_GATE_EN - normal commands issue only while hcount >= 640
//                         (horizontal blanking). hcount is unused otherwise.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-low reset
//   avs_chipselect  Avalon slave select
//   avs_write       Avalon write strobe
//   avs_writedata   command word from the host
//   avs_waitrequest high while the FIFO is full
//   hcount          VGA horizontal counter
//   vcount          VGA vertical counter
//   cmd_out         registered command pulse to the display stages
//   fifo_level      current FIFO occupancy
//   bad_cmd         sticky flag: a write with an unsupported info was dropped
// ---------------------------------------------------------------------------
module sprite_cmd_scheduler #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned V_ACTIVE = 480,
    parameter logic [31:0] CMD_IDLE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     avs_chipselect,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic                     avs_waitrequest,
    input  logic [9:0]               hcount,
    input  logic [9:0]               vcount,
    output logic [31:0]              cmd_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     bad_cmd
);

    localparam int unsigned AW          = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL  = (AW + 1)'(DEPTH);
    localparam logic [3:0]  INFO_NORMAL = 4'h1;
    localparam logic [3:0]  INFO_SWAP   = 4'hF;
    localparam logic [9:0]  VBLANK_LINE = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_VB,
        SWAP
    } state_t;

    state_t state, state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;

    logic        full;
    logic        empty;
    logic        accept;
    logic        wr_valid;
    logic        push;
    logic        pop;
    logic        load;
    logic        swap_done;
    logic        swap_armed;
    logic        in_vblank;
    logic        normal_ok;
    logic [31:0] head;
    logic [3:0]  head_info;
    logic [3:0]  wr_info;

    // ------------------------------------------------------------------
    // Host side: accept, classify, push
    // ------------------------------------------------------------------
    assign full            = (level == FULL_LEVEL);
    assign empty           = (level == '0);
    assign avs_waitrequest = full;

    assign wr_info  = avs_writedata[20:17];
    assign wr_valid = (wr_info == INFO_NORMAL) || (wr_info == INFO_SWAP);
    assign accept   = avs_chipselect && avs_write && !full;
    assign push     = accept && wr_valid;

    assign head      = mem[rd_ptr];
    assign head_info = head[20:17];

    assign in_vblank = (vcount >= VBLANK_LINE);

`ifdef SCHED_HSYNC_GATE_EN
    assign normal_ok = (hcount >= 10'd640);
`else
    logic unused_hcount;
    assign unused_hcount = ^hcount;
    assign normal_ok     = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by level)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= avs_writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign fifo_level = level;

    // ------------------------------------------------------------------
    // Sticky bad command flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_cmd <= 1'b0;
        end else if (accept && !wr_valid) begin
            bad_cmd <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // One swap per frame: cleared by the issued swap, re-armed once the
    // raster is back in the active region.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_armed <= 1'b1;
        end else if (swap_done) begin
            swap_armed <= 1'b0;
        end else if (!in_vblank) begin
            swap_armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        swap_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_info == INFO_SWAP) begin
                        // Going straight to SWAP when already in an armed
                        // vblank gives the swap the same 2-cycle latency
                        // as a normal command.
                        state_next = (in_vblank && swap_armed) ? SWAP : WAIT_VB;
                    end else if (normal_ok) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                load       = 1'b1;
                pop        = 1'b1;
                state_next = IDLE;
            end
            WAIT_VB: begin
                if (in_vblank && swap_armed) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                load       = 1'b1;
                pop        = 1'b1;
                swap_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: the head word for exactly one cycle, idle otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_out <= CMD_IDLE;
        end else if (load) begin
            cmd_out <= head;
        end else begin
            cmd_out <= CMD_IDLE;
        end
    end

endmodule
